// File: rtl/rs232c_rx_byte.sv
// rs232c_rx_byte -- RS-232C 8N1 byte receiver.
//
// Oversamples an asynchronous serial line with the system clock. The receiver
// finds the falling edge of the start bit and confirms it at mid-bit. It then
// samples each data bit in the middle of its period and checks the stop bit.
// Each recovered byte is presented with a single-cycle strobe.
//
// Parameters:
//   wtime   bit period in clk cycles (baud divisor), must be >= 4
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   rst      synchronous reset, active-high
//   rx       serial line, idle high, asynchronous to clk
//   data     last correctly received byte (LSB = first data bit)
//   changed  one-cycle pulse, data updated in the same cycle
//   ferr     one-cycle pulse on framing error (stop bit sampled low)
//   busy     high whenever a frame is in progress (state other than idle)
module rs232c_rx_byte #(
    parameter logic [15:0] wtime = 16'h0006
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       changed,
    output logic       ferr,
    output logic       busy
);

    localparam logic [15:0] half      = wtime >> 1;
    localparam logic [15:0] half_last = half - 16'd1;
    localparam logic [15:0] bit_last  = wtime - 16'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg;
    logic [7:0]  data_reg, data_next;
    logic        changed_reg, changed_next;
    logic        ferr_reg, ferr_next;
    logic        sample_data;
    logic [7:0]  bit_sel;

    // Two-flop synchronizer. The flops reset to the idle level so that
    // leaving reset never looks like a start edge.
    logic [1:0] sync_reg;
    logic       rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rx_s = sync_reg[1];

    // One-hot write enable per shift-register bit. Only the bit addressed by
    // the current bit index is loaded at the mid-bit sample point.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit_sel
            assign bit_sel[gi] = sample_data && (bit_idx_reg == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= 8'h00;
        end else begin
            shift_reg <= (shift_reg & ~bit_sel) | ({8{rx_s}} & bit_sel);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 16'd0;
            bit_idx_reg <= 3'd0;
            data_reg    <= 8'h00;
            changed_reg <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            data_reg    <= data_next;
            changed_reg <= changed_next;
            ferr_reg    <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        data_next    = data_reg;
        changed_next = 1'b0;
        ferr_next    = 1'b0;
        sample_data  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                cnt_next = 16'd0;
                if (!rx_s) begin
                    state_next = S_START;
                end
            end

            // Re-check the line half a bit after the edge. A line that is
            // high again here was a glitch, not a start bit.
            S_START: begin
                if (cnt_reg == half_last) begin
                    cnt_next     = 16'd0;
                    bit_idx_next = 3'd0;
                    state_next   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            // The counter is now phased to mid-bit, so each full bit period
            // lands on the centre of the next data bit.
            S_DATA: begin
                if (cnt_reg == bit_last) begin
                    sample_data  = 1'b1;
                    cnt_next     = 16'd0;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = S_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            // Decide in the middle of the stop bit. Returning to idle here
            // leaves half a bit of margin for an immediately following start.
            S_STOP: begin
                if (cnt_reg == bit_last) begin
                    cnt_next = 16'd0;
                    if (rx_s) begin
                        data_next    = shift_reg;
                        changed_next = 1'b1;
                        state_next   = S_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = S_BREAK;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end

            // The line is still low after a framing error. Stay here until it
            // returns to idle so that a held-low line cannot retrigger.
            S_BREAK: begin
                if (rx_s) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign data    = data_reg;
    assign changed = changed_reg;
    assign ferr    = ferr_reg;
    assign busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_rs232c_rx_byte.sv
// tb_rs232c_rx_byte -- self-checking bench for rs232c_rx_byte.
//
// The bench serialises bytes as 8N1 frames on rx, at wtime clocks per bit.
// The reference model is a queue of expected events per frame:
//   - a received byte when the stop bit is high;
//   - a framing error, carrying the last good byte, when the stop bit is low.
// A monitor collects the events the DUT actually produces. Each scenario
// ends by comparing the two queues entry by entry.
module tb_rs232c_rx_byte;

    localparam int W = 6;
    localparam int HALF = W / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       changed;
    logic       ferr;
    logic       busy;

    rs232c_rx_byte #(.wtime(16'(W))) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .data    (data),
        .changed (changed),
        .ferr    (ferr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         hold_err = 0;
    int         both_err = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] last_good = 8'h00;

    // Event encoding: {is_ferr, byte}
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: sample 1 ns after the rising edge, while inputs change on the falling edge.
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            if (changed) got_q.push_back({1'b0, data});
            if (ferr)    got_q.push_back({1'b1, data});
            if (changed && ferr) both_err++;
            if (!changed && data !== prev_data) hold_err++;
        end
        prev_data = data;
    end

    task automatic hold_line(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        hold_line(1'b0, W);
        for (int i = 0; i < 8; i++) hold_line(b[i], W);
        hold_line(stop_ok, W);
        if (stop_ok) begin
            exp_q.push_back({1'b0, b});
            last_good = b;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
    endtask

    task automatic compare(input string tag);
        hold_line(1'b1, 20);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            $display("txn %s[%0d] ferr=%0b data=%02h expected ferr=%0b data=%02h",
                     tag, i, got_q[i][8], got_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
            check($sformatf("%s_event%0d", tag, i), got_q[i], exp_q[i]);
        end
        check({tag, "_busy_idle"}, busy, 1'b0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;

        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", data, 8'h00);
        check("reset_changed", changed, 1'b0);
        check("reset_ferr", ferr, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        last_good = 8'h00;
        hold_line(1'b1, 5);

        // Single frame
        send_frame(8'h01, 1'b1);
        compare("single");

        // Back-to-back frames, no idle gap
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        compare("b2b");

        // End-marker bytes, then a normal byte
        for (int i = 0; i < 4; i++) send_frame(8'hFF, 1'b1);
        send_frame(8'hA5, 1'b1);
        compare("ff_run");

        // Two-cycle glitch on an idle line must be rejected
        hold_line(1'b0, 2);
        hold_line(1'b1, HALF + 3);
        check("glitch_busy", busy, 1'b0);
        compare("glitch");

        // Framing error, line held low, then recovery
        send_frame(8'h55, 1'b0);
        hold_line(1'b0, 20);
        check("ferr_hold_data", data, last_good);
        hold_line(1'b1, 12);
        send_frame(8'h3C, 1'b1);
        compare("ferr");

        // Reset in the middle of data bit 4. The upper nibble is all ones so
        // the rest of the abandoned frame cannot look like a new start bit.
        b = {4'hF, 4'($urandom_range(15))};
        hold_line(1'b0, W);
        for (int i = 0; i < 4; i++) hold_line(b[i], W);
        hold_line(b[4], HALF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        check("midreset_data", data, 8'h00);
        check("midreset_busy", busy, 1'b0);
        hold_line(b[4], W - HALF - 1);
        for (int i = 5; i < 8; i++) hold_line(b[i], W);
        hold_line(1'b1, W);
        compare("midreset");
        send_frame(8'h7E, 1'b1);
        compare("after_reset");

        // Random frames with random gaps and occasional framing errors
        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(9) != 0);
            send_frame(b, ok);
            if (!ok) hold_line(1'b1, $urandom_range(8, 2));
            else     hold_line(1'b1, $urandom_range(4, 0));
        end
        compare("random");

        check("data_hold", hold_err, 0);
        check("strobe_exclusive", both_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
